plc_timer_bank: RTL

- Parametrised bank of NUM_TIMERS PLC timer instructions for the ladder-scan engine.
- Replaces the hand-expanded per-timer PRE/EN/TT logic with one block.
- Each channel runs as TON, TOF or RTO off a shared internal millisecond-style time base.
- Rung inputs are sampled on the scan commit pulse, so timer state is consistent with the once-per-scan output commit.

---
 rtl/plc_timer_bank.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/plc_timer_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : plc_timer_bank                                             |
// | Description : Bank of NUM_TIMERS PLC timers (TON / TOF / RTO) sharing a  |
// |               prescaled time base; rung inputs latched on scan_commit.   |
// |               Define PLC_TIMER_DN_EDGE_EN to add the dn_rise output.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module plc_timer_bank #(
    parameter int NUM_TIMERS = 4,
    parameter int ACC_W      = 32,
    parameter int TICK_DIV   = 50000,
    parameter int SEL_W      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        scan_commit,
    input  logic [NUM_TIMERS-1:0]       en,
    input  logic [NUM_TIMERS-1:0]       res,
    input  logic [2*NUM_TIMERS-1:0]     mode,
    input  logic                        pre_wr,
    input  logic [SEL_W-1:0]            pre_sel,
    input  logic [ACC_W-1:0]            pre_data,
    output logic [NUM_TIMERS-1:0]       dn,
    output logic [NUM_TIMERS-1:0]       tt,
    output logic [NUM_TIMERS-1:0]       en_out,
`ifdef PLC_TIMER_DN_EDGE_EN
    output logic [NUM_TIMERS-1:0]       dn_rise,
`endif
    output logic [NUM_TIMERS*ACC_W-1:0] acc
);

    localparam int                  c_PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);

    localparam logic [1:0] c_MODE_TON = 2'b00;
    localparam logic [1:0] c_MODE_TOF = 2'b01;
    localparam logic [1:0] c_MODE_RTO = 2'b10;

    logic [c_PRESC_W-1:0]    r_presc;
    logic                    w_tick;
    logic [NUM_TIMERS-1:0]   r_en_q;
    logic [NUM_TIMERS-1:0]   r_res_q;
    logic [2*NUM_TIMERS-1:0] r_mode_q;

    // Free-running time base; tick is the last count of each period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (r_presc == c_PRESC_LAST) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PRESC_W'(1);
        end
    end

    assign w_tick = (r_presc == c_PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_q   <= '0;
            r_res_q  <= '0;
            r_mode_q <= '0;
        end else if (scan_commit) begin
            r_en_q   <= en;
            r_res_q  <= res;
            r_mode_q <= mode;
        end
    end

    assign en_out = r_en_q;

    generate
        for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_ch
            logic [ACC_W-1:0] r_pre;
            logic [ACC_W-1:0] r_acc;
            logic             r_dn;
            logic             r_tt;
            logic [ACC_W-1:0] w_acc_run;
            logic [ACC_W-1:0] w_acc_hold;
            logic [ACC_W-1:0] w_acc_n;
            logic             w_dn_n;
            logic             w_tt_n;
            logic [1:0]       w_mode;

            assign w_mode = r_mode_q[2*gi +: 2];

            // Advance one step per tick while below preset; otherwise sit at
            // preset, which also clamps acc after a preset is lowered.
            assign w_acc_run  = (r_acc < r_pre) ? (r_acc + ACC_W'(w_tick)) : r_pre;
            assign w_acc_hold = (r_acc < r_pre) ? r_acc : r_pre;

            always_comb begin
                w_acc_n = '0;
                w_dn_n  = 1'b0;
                w_tt_n  = 1'b0;
                if (!r_res_q[gi]) begin
                    case (w_mode)
                        c_MODE_TOF: begin
                            if (r_en_q[gi]) begin
                                w_dn_n = 1'b1;
                            end else begin
                                w_acc_n = w_acc_run;
                                w_tt_n  = (w_acc_run < r_pre);
                                w_dn_n  = (w_acc_run < r_pre);
                            end
                        end
                        c_MODE_RTO: begin
                            if (r_en_q[gi]) begin
                                w_acc_n = w_acc_run;
                                w_tt_n  = (w_acc_run < r_pre);
                                w_dn_n  = !(w_acc_run < r_pre);
                            end else begin
                                w_acc_n = w_acc_hold;
                                w_dn_n  = r_dn;
                            end
                        end
                        default: begin
                            if (r_en_q[gi]) begin
                                w_acc_n = w_acc_run;
                                w_tt_n  = (w_acc_run < r_pre);
                                w_dn_n  = !(w_acc_run < r_pre);
                            end
                        end
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pre <= '0;
                end else if (pre_wr && (32'(pre_sel) == gi)) begin
                    r_pre <= pre_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc <= '0;
                    r_dn  <= 1'b0;
                    r_tt  <= 1'b0;
                end else begin
                    r_acc <= w_acc_n;
                    r_dn  <= w_dn_n;
                    r_tt  <= w_tt_n;
                end
            end

`ifdef PLC_TIMER_DN_EDGE_EN
            logic r_dn_rise;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dn_rise <= 1'b0;
                end else begin
                    r_dn_rise <= w_dn_n & ~r_dn;
                end
            end

            assign dn_rise[gi] = r_dn_rise;
`endif

            assign acc[gi*ACC_W +: ACC_W] = r_acc;
            assign dn[gi]                 = r_dn;
            assign tt[gi]                 = r_tt;
        end
    endgenerate

endmodule
`default_nettype wire
